timer_apb_regif: RTL and testbench
==================================

TIMER_APB_REGIF -- requirements
Module: timer_apb_regif

Interface
REQ-001 SHALL have parameter WAIT, default 0, meaning the number of wait cycles inserted before pready on every transfer (legal range 0..15).
REQ-002 SHALL have ports pclk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have preset_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have the following APB ports:
- psel, input, 1, slave select.
- penable, input, 1, access phase.
- pwrite, input, 1, 1 = write.
- paddr, input, 8, register address.
- pwdata, input, 8, write data.
- prdata, output, 8, read data.
- pready, output, 1, transfer complete.
- pslverr, output, 1, error response.
REQ-005 SHALL have the following core-side ports:
- tdr_o, output, 8, reload value.
- tcr_o, output, 8, control register.
- load_pulse_o, output, 1, one-cycle reload strobe.
- cnt_i, input, 8, live counter value.
- ovf_set_i, input, 1, overflow event.
- udf_set_i, input, 1, underflow event.
- tsr_o, output, 2, status flags.

Function
REQ-006 SHALL decode the following addresses:
- 0x00 TDR, RW, 8 bits.
- 0x01 TCR, RW: bit7 LOAD, bit5 DOWN, bit4 EN, bits1:0 CKS; bits 6,3,2 read 0 and ignore writes.
- 0x02 TSR, bits1:0 {UDF,OVF}, write-1-to-clear.
- 0x03 TCNT, read-only, returns cnt_i.
REQ-007 SHALL run a transfer FSM with states IDLE, SETUP, WAIT, ACCESS:
- IDLE->SETUP on psel=1, penable=0.
- SETUP->WAIT when WAIT>0, else SETUP->ACCESS.
- WAIT stays for WAIT cycles, then ->ACCESS.
- ACCESS->IDLE.
REQ-008 SHALL drive pready=1 only in the ACCESS state while psel=1 and penable=1; a WAIT=0 transfer completes in the first access-phase cycle.
REQ-009 SHALL commit writes only on the rising edge where psel, penable, pwrite and pready are all 1.
REQ-010 SHALL drive prdata with the addressed register value while pready=1 on a read, and 0x00 at all other times.
REQ-011 SHALL assert pslverr with pready for paddr>0x03 or a write to 0x03, perform no register update in that case, and return prdata=0x00.
REQ-012 SHALL, if psel drops before pready, return to IDLE without committing a write or raising an error.
REQ-013 SHALL, when TCR is written with bit7=1, pulse load_pulse_o for exactly one cycle after the commit edge; the stored TCR bit7 SHALL self-clear on that same following edge, so a read always returns LOAD=0.
REQ-014 SHALL set a TSR bit on the cycle after ovf_set_i/udf_set_i is high; writing 1 clears the bit; a set and a clear in the same cycle leave the bit set.
REQ-015 SHALL drive tdr_o, tcr_o and tsr_o continuously from the registers, updating one cycle after the commit edge.
REQ-016 SHALL let back-to-back transfers (new SETUP in the cycle after ACCESS) proceed with no lost cycle.

Reset
REQ-017 SHALL, when preset_n=0 at a rising edge, force the following on that edge, irrespective of other inputs:
- TDR=0x00, TCR=0x00, TSR=2'b00.
- FSM=IDLE.
- prdata=0x00, pready=0, pslverr=0, load_pulse_o=0.
REQ-018 SHALL, on reset mid-transfer, abandon the transfer with no write committed.

Structure
REQ-019 SHALL place the register address constants (0x00..0x03), TCR bit positions and FSM state encoding in shared package timer_pkg.
REQ-020 SHALL implement the wait-state counter as the single sub-module timer_wait_cnt (load WAIT on SETUP, decrement, flag zero); all other logic stays in timer_apb_regif.

Verification
REQ-021 SHALL cover the following directed scenarios (WAIT=0 unless stated):
- Write 0x10 to 0x01, read 0x01 -> prdata=0x10, tcr_o=0x10, pslverr=0.
- Write 0x90 to 0x01 -> load_pulse_o high exactly 1 cycle; read 0x01 -> 0x10.
- ovf_set_i pulse, then write 0x01 to 0x02 in the same cycle as a second ovf_set_i -> TSR stays 0x01; a later write of 0x01 -> TSR=0x00.
- WAIT=3: read 0x03 with cnt_i=0x5A -> pready high exactly 4 cycles after SETUP, prdata=0x5A.
- Write to 0x07 and to 0x03 -> pslverr=1 with pready, all registers unchanged.
- preset_n=0 during a WAIT=3 write of 0xFF to 0x00 -> TDR remains 0x00, FSM IDLE, pready=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer APB register block: register map, TCR bit
// positions and the bus transfer state encoding.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  localparam int TCR_LOAD = 7;
  localparam int TCR_DOWN = 5;
  localparam int TCR_EN   = 4;

  // Writable TCR bits: LOAD, DOWN, EN and the two CKS bits.
  localparam logic [7:0] TCR_WMASK = 8'((1 << TCR_LOAD) | (1 << TCR_DOWN) | (1 << TCR_EN) | 3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_ACCESS
  } apb_state_e;

endpackage

// File: rtl/timer_wait_cnt.sv
// Wait-state counter: loads WAIT at the start of a transfer and counts down,
// flagging the last wait cycle so the transfer FSM can move to ACCESS.
module timer_wait_cnt #(
  parameter int unsigned WAIT = 0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'(WAIT);
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    last_o = (cnt_q <= 4'd1);
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_apb_regif.sv
// APB slave register interface for the timer core: TDR/TCR/TSR/TCNT decode,
// wait-state transfer FSM, LOAD strobe and sticky status flags.
module timer_apb_regif
  import timer_pkg::*;
#(
  parameter int unsigned WAIT = 0
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] tdr_o,
  output logic [7:0] tcr_o,
  output logic       load_pulse_o,
  input  logic [7:0] cnt_i,
  input  logic       ovf_set_i,
  input  logic       udf_set_i,
  output logic [1:0] tsr_o
);

  apb_state_e state_q, state_d, cur_state;
  logic       wait_last;
  logic [7:0] tdr_q, tdr_d, tcr_q, tcr_d;
  logic [1:0] tsr_q, tsr_d;
  logic       load_pulse_q, load_pulse_d;
  logic       addr_err, commit;
  logic [7:0] rd_val;

  timer_wait_cnt #(.WAIT(WAIT)) u_wait_cnt (
    .pclk     (pclk),
    .preset_n (preset_n),
    .load_i   (cur_state == ST_SETUP),
    .dec_i    (state_q == ST_WAIT),
    .last_o   (wait_last)
  );

  // SETUP is the APB setup-phase cycle itself, so it is decoded from IDLE
  // rather than registered; this lets a WAIT=0 transfer finish in its first
  // access cycle and lets back-to-back transfers start right after ACCESS.
  always_comb begin
    cur_state = state_q;
    if ((state_q == ST_IDLE) && psel && !penable) begin
      cur_state = ST_SETUP;
    end
    state_d = state_q;
    case (cur_state)
      ST_IDLE:   state_d = ST_IDLE;
      ST_SETUP:  state_d = (WAIT > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (wait_last) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_err = (paddr > ADDR_TCNT) || (pwrite && (paddr == ADDR_TCNT));
    pready   = (cur_state == ST_ACCESS) && psel && penable;
    pslverr  = pready && addr_err;
    commit   = pready && pwrite && !addr_err;
    rd_val   = 8'h00;
    case (paddr)
      ADDR_TDR:  rd_val = tdr_q;
      ADDR_TCR: begin
        rd_val           = tcr_q;
        rd_val[TCR_LOAD] = 1'b0;
      end
      ADDR_TSR:  rd_val = {6'b0, tsr_q};
      ADDR_TCNT: rd_val = cnt_i;
      default:   rd_val = 8'h00;
    endcase
    prdata = (pready && !pwrite && !addr_err) ? rd_val : 8'h00;
  end

  // LOAD lives in TCR for exactly one cycle alongside the strobe, then clears.
  always_comb begin
    tdr_d           = tdr_q;
    tcr_d           = tcr_q;
    tcr_d[TCR_LOAD] = 1'b0;
    tsr_d           = tsr_q;
    load_pulse_d    = 1'b0;
    if (commit && (paddr == ADDR_TDR)) begin
      tdr_d = pwdata;
    end
    if (commit && (paddr == ADDR_TCR)) begin
      tcr_d        = pwdata & TCR_WMASK;
      load_pulse_d = pwdata[TCR_LOAD];
    end
    if (commit && (paddr == ADDR_TSR)) begin
      tsr_d = tsr_q & ~pwdata[1:0];
    end
    tsr_d = tsr_d | {udf_set_i, ovf_set_i};
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q      <= ST_IDLE;
      tdr_q        <= 8'h00;
      tcr_q        <= 8'h00;
      tsr_q        <= 2'b00;
      load_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tdr_q        <= tdr_d;
      tcr_q        <= tcr_d;
      tsr_q        <= tsr_d;
      load_pulse_q <= load_pulse_d;
    end
  end

  assign tdr_o        = tdr_q;
  assign tcr_o        = tcr_q;
  assign tsr_o        = tsr_q;
  assign load_pulse_o = load_pulse_q;

endmodule

// File: tb/tb_timer_apb_regif.sv
// Directed self-checking bench for timer_apb_regif: one WAIT=0 and one WAIT=3
// instance sharing the bus inputs, with psel steered to the selected one.
module tb_timer_apb_regif;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       psel, penable, pwrite, w3_sel;
  logic [7:0] paddr, pwdata, cnt_i;
  logic       ovf_set, udf_set;

  logic [7:0] prdata0, tdr0, tcr0, prdata3, tdr3, tcr3;
  logic       pready0, pslverr0, load0, pready3, pslverr3, load3;
  logic [1:0] tsr0, tsr3;
  logic       psel0, psel3, cur_pready, cur_pslverr;
  logic [7:0] cur_prdata;

  int num_checks = 0;
  int num_fail   = 0;

  always #5 pclk = ~pclk;

  assign psel0       = psel && !w3_sel;
  assign psel3       = psel && w3_sel;
  assign cur_pready  = w3_sel ? pready3  : pready0;
  assign cur_pslverr = w3_sel ? pslverr3 : pslverr0;
  assign cur_prdata  = w3_sel ? prdata3  : prdata0;

  timer_apb_regif #(.WAIT(0)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .tdr_o(tdr0), .tcr_o(tcr0),
    .load_pulse_o(load0), .cnt_i(cnt_i), .ovf_set_i(ovf_set),
    .udf_set_i(udf_set), .tsr_o(tsr0)
  );

  timer_apb_regif #(.WAIT(3)) u_dut3 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .tdr_o(tdr3), .tcr_o(tcr3),
    .load_pulse_o(load3), .cnt_i(cnt_i), .ovf_set_i(ovf_set),
    .udf_set_i(udf_set), .tsr_o(tsr3)
  );

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
    end
  endtask

  // One full APB transfer; returns at the negedge after the commit edge.
  task automatic applyStimulus(input logic use_w3, input logic wr, input logic [7:0] addr,
                               input logic [7:0] data, output logic [7:0] rd,
                               output logic err, output int lat);
    @(negedge pclk);
    w3_sel = use_w3; psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    lat = 1;
    #1;
    while (!cur_pready && lat < 40) begin
      @(negedge pclk);
      lat++;
      #1;
    end
    if (!cur_pready) checkOutput("pready_timeout", 8'd0, 8'd1);
    rd  = cur_prdata;
    err = cur_pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
  endtask

  logic [7:0] rd;
  logic       err;
  int         lat;
  logic       seen_ready;

  initial begin
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; w3_sel = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; cnt_i = 8'h00; ovf_set = 1'b0; udf_set = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    checkOutput("rst_tdr", tdr0, 8'h00);
    checkOutput("rst_tcr", tcr0, 8'h00);
    checkOutput("rst_tsr", 8'(tsr0), 8'h00);
    checkOutput("rst_pready", 8'(pready0), 8'd0);
    checkOutput("rst_prdata", prdata0, 8'h00);
    checkOutput("rst_load", 8'(load0), 8'd0);
    @(negedge pclk);
    preset_n = 1'b1;

    applyStimulus(1'b0, 1'b1, 8'h01, 8'h10, rd, err, lat);
    checkOutput("tcr_wr_err", 8'(err), 8'd0);
    checkOutput("tcr_o_10", tcr0, 8'h10);
    checkOutput("wr_latency_w0", 8'(lat), 8'd1);
    applyStimulus(1'b0, 1'b0, 8'h01, 8'h00, rd, err, lat);
    checkOutput("tcr_rd_10", rd, 8'h10);
    checkOutput("tcr_rd_err", 8'(err), 8'd0);

    applyStimulus(1'b0, 1'b1, 8'h01, 8'h90, rd, err, lat);
    checkOutput("load_pulse_hi", 8'(load0), 8'd1);
    checkOutput("tcr_o_90", tcr0, 8'h90);
    @(negedge pclk); #1;
    checkOutput("load_pulse_lo", 8'(load0), 8'd0);
    checkOutput("tcr_o_selfclr", tcr0, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h01, 8'h00, rd, err, lat);
    checkOutput("tcr_rd_after_load", rd, 8'h10);

    applyStimulus(1'b0, 1'b1, 8'h00, 8'hA5, rd, err, lat);
    checkOutput("tdr_o_a5", tdr0, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, rd, err, lat);
    checkOutput("tdr_rd_a5", rd, 8'hA5);

    applyStimulus(1'b0, 1'b1, 8'h01, 8'hFF, rd, err, lat);
    checkOutput("tcr_o_ff_masked", tcr0, 8'hB3);
    applyStimulus(1'b0, 1'b0, 8'h01, 8'h00, rd, err, lat);
    checkOutput("tcr_rd_ff_masked", rd, 8'h33);

    cnt_i = 8'h3C;
    applyStimulus(1'b0, 1'b0, 8'h03, 8'h00, rd, err, lat);
    checkOutput("tcnt_rd_w0", rd, 8'h3C);
    checkOutput("rd_latency_w0", 8'(lat), 8'd1);

    @(negedge pclk); ovf_set = 1'b1;
    @(negedge pclk); ovf_set = 1'b0; #1;
    checkOutput("tsr_ovf_set", 8'(tsr0), 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h02, 8'h00, rd, err, lat);
    checkOutput("tsr_rd_ovf", rd, 8'h01);
    ovf_set = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h01, rd, err, lat);
    ovf_set = 1'b0;
    checkOutput("tsr_set_wins", 8'(tsr0), 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h01, rd, err, lat);
    checkOutput("tsr_w1c_ovf", 8'(tsr0), 8'h00);
    @(negedge pclk); udf_set = 1'b1;
    @(negedge pclk); udf_set = 1'b0; #1;
    checkOutput("tsr_udf_set", 8'(tsr0), 8'h02);
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h03, rd, err, lat);
    checkOutput("tsr_w1c_udf", 8'(tsr0), 8'h00);

    applyStimulus(1'b0, 1'b1, 8'h07, 8'h55, rd, err, lat);
    checkOutput("err_wr_07", 8'(err), 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h03, 8'h66, rd, err, lat);
    checkOutput("err_wr_03", 8'(err), 8'd1);
    applyStimulus(1'b0, 1'b0, 8'h07, 8'h00, rd, err, lat);
    checkOutput("err_rd_07", 8'(err), 8'd1);
    checkOutput("err_rd_data", rd, 8'h00);
    checkOutput("err_tdr_keep", tdr0, 8'hA5);
    checkOutput("err_tcr_keep", tcr0, 8'h33);
    checkOutput("err_tsr_keep", 8'(tsr0), 8'h00);
    checkOutput("idle_prdata", prdata0, 8'h00);

    cnt_i = 8'h5A;
    applyStimulus(1'b1, 1'b0, 8'h03, 8'h00, rd, err, lat);
    checkOutput("w3_latency", 8'(lat), 8'd4);
    checkOutput("w3_tcnt_rd", rd, 8'h5A);
    checkOutput("w3_rd_err", 8'(err), 8'd0);

    @(negedge pclk);
    w3_sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (5) @(negedge pclk);
    #1;
    checkOutput("abort_no_write", tdr3, 8'h00);

    applyStimulus(1'b1, 1'b1, 8'h00, 8'h77, rd, err, lat);
    checkOutput("w3_tdr_77", tdr3, 8'h77);

    @(negedge pclk);
    w3_sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hFF;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); preset_n = 1'b0;
    @(negedge pclk); preset_n = 1'b1; #1;
    checkOutput("midrst_pready", 8'(pready3), 8'd0);
    checkOutput("midrst_tdr", tdr3, 8'h00);
    seen_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk); #1;
      if (pready3) seen_ready = 1'b1;
    end
    checkOutput("midrst_fsm_idle", 8'(seen_ready), 8'd0);
    checkOutput("midrst_tdr_after", tdr3, 8'h00);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
